// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment resolved per
// stage, with the carry and the not-yet-added operand bits registered between stages.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned NSEG = WIDTH / SEG_W;
    localparam int unsigned NGRP = SEG_W / 4;

    if (((SEG_W % 4) != 0) || ((WIDTH % SEG_W) != 0) || (NSEG == 0)) begin : g_cfg_err
        $error("pipelined_cla_adder: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Global stall: every stage moves together or holds together.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = b ^ {WIDTH{sub}};
    assign cin_eff  = sub | cin;

    // One segment of 4-bit lookahead groups, carry rippling group to group; returns {cout, sum}.
    function automatic logic [SEG_W:0] seg_add(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             ci
    );
        logic [SEG_W-1:0] s;
        logic [3:0]       g;
        logic [3:0]       p;
        logic [4:0]       c;
        logic             co;
        s  = '0;
        co = ci;
        for (int j = 0; j < int'(NGRP); j++) begin
            g    = x[4*j +: 4] & y[4*j +: 4];
            p    = x[4*j +: 4] ^ y[4*j +: 4];
            c[0] = co;
            c[1] = g[0] | (p[0] & c[0]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c[0]);
            s[4*j +: 4] = p ^ c[3:0];
            co = c[4];
        end
        return {co, s};
    endfunction

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int unsigned RIN = WIDTH - k*SEG_W;   // operand bits still to add at stage input
        localparam int unsigned HI  = (k+1)*SEG_W;       // sum bits resolved after this stage

        logic [RIN-1:0]   a_in;
        logic [RIN-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [HI-1:0]    s_nxt;
        logic [SEG_W-1:0] seg_s;
        logic             seg_co;
        logic             v_r;
        logic [HI-1:0]    s_r;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = cin_eff;
            assign v_in  = in_valid;
            assign s_nxt = seg_s;
        end else begin : g_src
            assign a_in  = g_stg[k-1].g_skew.a_r;
            assign b_in  = g_stg[k-1].g_skew.b_r;
            assign c_in  = g_stg[k-1].g_skew.c_r;
            assign v_in  = g_stg[k-1].v_r;
            assign s_nxt = {seg_s, g_stg[k-1].s_r};
        end

        assign {seg_co, seg_s} = seg_add(a_in[SEG_W-1:0], b_in[SEG_W-1:0], c_in);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_in;
                s_r <= s_nxt;
            end
        end

        if (k < NSEG-1) begin : g_skew
            logic [RIN-SEG_W-1:0] a_r;
            logic [RIN-SEG_W-1:0] b_r;
            logic                 c_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                end else if (advance) begin
                    a_r <= a_in[RIN-1:SEG_W];
                    b_r <= b_in[RIN-1:SEG_W];
                    c_r <= seg_co;
                end
            end
        end else begin : g_last
            logic cout_r;
            logic ovf_r;
            logic zero_r;

            // Carry into the MSB is recovered from the MSB sum and operand bits.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cout_r <= 1'b0;
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (advance) begin
                    cout_r <= seg_co;
                    ovf_r  <= seg_co ^ (seg_s[SEG_W-1] ^ a_in[SEG_W-1] ^ b_in[SEG_W-1]);
                    zero_r <= ~|s_nxt;
                end
            end
        end
    end

    assign out_valid = g_stg[NSEG-1].v_r;
    assign sum       = g_stg[NSEG-1].s_r;
    assign cout      = g_stg[NSEG-1].g_last.cout_r;
    assign ovf       = g_stg[NSEG-1].g_last.ovf_r;
    assign zero      = g_stg[NSEG-1].g_last.zero_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at 32/8, 16/4 and 8/8 configurations,
// with an arithmetic reference model and randomized backpressure.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        cin, sub;
    logic        iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2;
    logic        ordy0, ordy_hi;
    logic [31:0] sum0;
    logic [15:0] sum1;
    logic [7:0]  sum2;
    logic        co0, co1, co2, vf0, vf1, vf2, z0, z1, z2;

    int   checks   = 0;
    int   failures = 0;
    bit   bp_en    = 1'b0;
    res_t q0[$], q1[$], q2[$];
    bit   prev_stall [3];
    res_t prev_res   [3];

    pipelined_cla_adder #(.WIDTH(32), .SEG_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov0), .out_ready(ordy0), .sum(sum0), .cout(co0), .ovf(vf0), .zero(z0));
    pipelined_cla_adder #(.WIDTH(16), .SEG_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(ordy_hi), .sum(sum1), .cout(co1), .ovf(vf1), .zero(z1));
    pipelined_cla_adder #(.WIDTH(8), .SEG_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov2), .out_ready(ordy_hi), .sum(sum2), .cout(co2), .ovf(vf2), .zero(z2));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic res_t mk(input logic [31:0] s, input logic co, input logic vf, input logic z);
        res_t r;
        r.sum = s; r.cout = co; r.ovf = vf; r.zero = z;
        return r;
    endfunction

    // Reference: plain unbounded unsigned and signed arithmetic at width w.
    function automatic res_t model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                   input logic tc, input logic ts);
        longint m  = (longint'(1) << w) - 1;
        longint h  = longint'(1) << (w - 1);
        longint ua = longint'(ta) & m;
        longint ub = longint'(tb) & m;
        longint sa = (ua >= h) ? ua - (m + 1) : ua;
        longint sb = (ub >= h) ? ub - (m + 1) : ub;
        longint r, sr;
        res_t   e;
        if (ts) begin
            r = ua - ub; sr = sa - sb; e.cout = (ua >= ub);
        end else begin
            r = ua + ub + longint'(tc); sr = sa + sb + longint'(tc); e.cout = (r > m);
        end
        e.sum  = 32'(r & m);
        e.ovf  = (sr >= h) || (sr < -h);
        e.zero = ((r & m) == 0);
        return e;
    endfunction

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic ovs(input int sel);
        case (sel)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic void set_iv(input int sel, input logic v);
        case (sel)
            0:       iv0 = v;
            1:       iv1 = v;
            default: iv2 = v;
        endcase
    endfunction

    function automatic void push(input int sel, input res_t e);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic bit pop(input int sel, output res_t e);
        e = '0;
        case (sel)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Output monitor: handshake rule, stall stability, in-order scoreboard match.
    function automatic void mon(input int sel, input logic ov, input logic ordy, input logic ir, input res_t got);
        res_t  e;
        string tag = $sformatf("dut%0d", sel);
        chk({tag, " in_ready"}, 64'(ir), 64'(!ov || ordy));
        if (prev_stall[sel]) begin
            chk({tag, " stall valid"}, 64'(ov), 64'(1'b1));
            chk({tag, " stall hold"}, 64'(got), 64'(prev_res[sel]));
        end
        if (ov && ordy) begin
            if (!pop(sel, e)) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected beat: got sum 0x%0h, expected no output", tag, got.sum);
            end else begin
                chk({tag, " sum"}, 64'(got.sum), 64'(e.sum));
                chk({tag, " flags cout/ovf/zero"}, 64'({got.cout, got.ovf, got.zero}),
                    64'({e.cout, e.ovf, e.zero}));
            end
        end
        prev_stall[sel] = ov && !ordy;
        prev_res[sel]   = got;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov0, ordy0,   ir0, mk(sum0, co0, vf0, z0));
            mon(1, ov1, ordy_hi, ir1, mk(32'(sum1), co1, vf1, z1));
            mon(2, ov2, ordy_hi, ir2, mk(32'(sum2), co2, vf2, z2));
        end else begin
            for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            ordy0 = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int sel, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts, input res_t e);
        int n = 0;
        a = ta; b = tb; cin = tc; sub = ts;
        set_iv(sel, 1'b1);
        forever begin
            @(negedge clk);
            if (rdy(sel)) break;
            n++;
            if (n > 200) break;
        end
        if (rdy(sel)) push(sel, e);
        else begin
            checks++;
            failures++;
            $display("FAIL dut%0d accept timeout: in_ready 0, expected 1 within 200 cycles", sel);
        end
        @(posedge clk);
        #1;
        set_iv(sel, 1'b0);
    endtask

    task automatic lat_check(input int sel, input int lat);
        int cyc = 1;
        while (!ovs(sel) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("dut%0d latency", sel), 64'(cyc), 64'(lat));
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain pending beats", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic directed(input int sel, input int w, input int lat);
        logic [31:0] m = 32'((64'd1 << w) - 1);
        logic [31:0] h = 32'(64'd1 << (w - 1));
        send(sel, m, 32'd1, 1'b0, 1'b0, mk(32'd0, 1'b1, 1'b0, 1'b1));
        lat_check(sel, lat);
        send(sel, h - 32'd1, 32'd0, 1'b1, 1'b0, mk(h, 1'b0, 1'b1, 1'b0));
        if (w >= 16) send(sel, 32'h0F, 32'hF0, 1'b1, 1'b0, mk(32'h100, 1'b0, 1'b0, 1'b0));
        send(sel, 32'd5, 32'd7, 1'b1, 1'b1, mk(m - 32'd1, 1'b0, 1'b0, 1'b0));
        send(sel, h, 32'd1, 1'b0, 1'b1, mk(h - 32'd1, 1'b1, 1'b1, 1'b0));
        drain();
    endtask

    task automatic rand_beats(input int sel, input int w, input int n);
        logic [31:0] ta, tb;
        logic        tc, ts;
        for (int i = 0; i < n; i++) begin
            ta = $urandom;
            tb = (i % 5 == 0) ? ta : $urandom;
            tc = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            send(sel, ta, tb, tc, ts, model(w, ta, tb, tc, ts));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; ordy0 = 1'b1; ordy_hi = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'({ov0, ov1, ov2}), 64'(0));
        chk("reset sum", 64'(sum0), 64'(0));
        chk("reset flags", 64'({co0, vf0, z0}), 64'(0));
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 64'({ir0, ir1, ir2}), 64'(3'b111));

        directed(0, 32, 4);
        directed(1, 16, 4);
        directed(2, 8, 1);
        rand_beats(1, 16, 20);
        rand_beats(2, 8, 20);
        drain();

        bp_en = 1'b1;
        rand_beats(0, 32, 16);
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        ordy0 = 1'b0;

        rand_beats(0, 32, 3);
        @(posedge clk);
        #1;
        chk("stalled head valid", 64'(ov0), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid-flight reset out_valid", 64'(ov0), 64'(0));
        chk("mid-flight reset sum", 64'(sum0), 64'(0));
        chk("mid-flight reset flags", 64'({co0, vf0, z0}), 64'(0));
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("release in_ready", 64'(ir0), 64'(1));
        ordy0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle after reset out_valid", 64'(ov0), 64'(0));
        end
        @(posedge clk);
        #1;
        send(0, 32'h1234, 32'h4321, 1'b0, 1'b0, mk(32'h5555, 1'b0, 1'b0, 1'b0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
